uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: i_rx_data  input  8  byte from UART receiver; valid only in the cycle i_rx_done=1.
REQ-004 SHALL have: i_rx_done  input  1  one-cycle strobe, receiver byte ready.
REQ-005 SHALL have: i_tx_busy  input  1  UART transmitter busy level.
REQ-006 SHALL have: o_tx_data  output  8  byte to transmitter; held stable while o_tx_start=1.
REQ-007 SHALL have: o_tx_start  output  1  one-cycle transmit request.
REQ-008 SHALL have: o_btn_run_stop, o_btn_clear, o_btn_mode, o_btn_up, o_btn_down  output  1 each  one-cycle command pulses to the stopwatch/watch control units.
REQ-009 SHALL have: o_mode_sel  output  1  level: 0=stopwatch, 1=watch.
REQ-010 SHALL have: o_setting  output  1  level: watch setting mode.
REQ-011 SHALL have: o_digit_sel  output  4  one-hot: [3]=hour, [2]=min, [1]=sec, [0]=msec.
REQ-012 SHALL have: o_err  output  1  one-cycle pulse on an unknown byte; o_overrun  output  1  one-cycle pulse on a dropped byte.

Function
REQ-013 SHALL use FSM states IDLE, DECODE, ECHO, ECHO_HOLD.
REQ-014 IDLE: when i_rx_done=1, SHALL latch i_rx_data and go to DECODE.
REQ-015 SHALL fold bytes 0x41-0x5A to lower case by setting bit 5; all other bytes SHALL pass unchanged.
REQ-016 DECODE (cycle N+1, where N is the cycle i_rx_done is sampled) SHALL apply the folded byte:
 - 'r' -> o_btn_run_stop; 'c' -> o_btn_clear; 'm' -> o_btn_mode; 'u' -> o_btn_up; 'd' -> o_btn_down, each a pulse for exactly one cycle.
 - 'w' -> toggle o_mode_sel; 's' -> toggle o_setting.
 - '0'/'1'/'2'/'3' -> o_digit_sel = 4'b0001/0010/0100/1000.
 - 0x0D or 0x0A -> no action, no error, no echo.
 - any other byte -> o_err pulse.
REQ-017 At most one command pulse SHALL be high in any cycle.
REQ-018 DECODE SHALL last exactly one cycle, then go to ECHO (when echo is compiled in and the byte is not CR/LF) or to IDLE.
REQ-019 ECHO: SHALL wait while i_tx_busy=1; on the first cycle with i_tx_busy=0, SHALL assert o_tx_start for one cycle with o_tx_data = raw latched byte, or 0x3F ('?') for an unknown byte, then go to ECHO_HOLD.
REQ-020 ECHO_HOLD SHALL last one cycle, covering the transmitter's busy rise latency, then go to IDLE.
REQ-021 An i_rx_done strobe in any state other than IDLE SHALL drop the byte, pulse o_overrun in the same cycle, and leave the state unchanged.
REQ-022 o_tx_data SHALL hold its last value between transmissions.

Reset
REQ-023 Reset SHALL force: state IDLE, all pulses 0, o_tx_start 0, o_tx_data 8'h00, o_mode_sel 0, o_setting 0, o_digit_sel 4'b0001, latched byte 8'h00.
REQ-024 Reset asserted mid-echo SHALL abort the echo; no o_tx_start SHALL be issued after reset releases.

Configuration
REQ-025 Macro UART_CMD_ECHO_EN defined: ECHO and ECHO_HOLD states exist, and echo behaves per REQ-019/020.
REQ-026 Macro UART_CMD_ECHO_EN undefined: DECODE SHALL always return to IDLE; o_tx_start SHALL be constant 0 and o_tx_data constant 8'h00; i_tx_busy is ignored.

Structure
REQ-027 Shared package uart_cmd_pkg SHALL hold the ASCII command constants, the CR/LF/'?' constants, and the state encoding.
REQ-028 SHALL contain one sub-module, cmd_lookup: combinational folded byte -> command-code/valid mapping.

Verification
REQ-029 After reset, rx 0x72 'r' -> o_btn_run_stop high exactly one cycle, at rx_done+1; echo 0x72 with tx_busy=0 -> o_tx_start at rx_done+2.
REQ-030 rx 0x57 'W', then 0x77 'w' -> o_mode_sel goes 1 then 0; echoes are 0x57 then 0x77.
REQ-031 rx 0x32 '2' -> o_digit_sel=4'b0100; rx 0x78 'x' -> o_err pulse, echo 0x3F, o_digit_sel unchanged.
REQ-032 Hold tx_busy=1 for 50 cycles, rx 'c' -> o_btn_clear at rx_done+1; o_tx_start on the first cycle after busy falls; a second rx_done during the wait -> o_overrun pulse, no second echo.
REQ-033 Reset asserted during ECHO wait -> all outputs at reset values, no o_tx_start afterwards; build without UART_CMD_ECHO_EN, rx 'u' -> o_btn_up pulse, o_tx_start never asserts.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants, command codes and state encoding for the UART command decoder.
package uart_cmd_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [BYTE_W-1:0] CH_RUN_STOP = 8'h72; // 'r'
  localparam logic [BYTE_W-1:0] CH_CLEAR    = 8'h63; // 'c'
  localparam logic [BYTE_W-1:0] CH_MODE     = 8'h6D; // 'm'
  localparam logic [BYTE_W-1:0] CH_UP       = 8'h75; // 'u'
  localparam logic [BYTE_W-1:0] CH_DOWN     = 8'h64; // 'd'
  localparam logic [BYTE_W-1:0] CH_WATCH    = 8'h77; // 'w'
  localparam logic [BYTE_W-1:0] CH_SETTING  = 8'h73; // 's'
  localparam logic [BYTE_W-1:0] CH_DIGIT0   = 8'h30; // '0'
  localparam logic [BYTE_W-1:0] CH_DIGIT1   = 8'h31; // '1'
  localparam logic [BYTE_W-1:0] CH_DIGIT2   = 8'h32; // '2'
  localparam logic [BYTE_W-1:0] CH_DIGIT3   = 8'h33; // '3'
  localparam logic [BYTE_W-1:0] CH_CR       = 8'h0D;
  localparam logic [BYTE_W-1:0] CH_LF       = 8'h0A;
  localparam logic [BYTE_W-1:0] CH_QMARK    = 8'h3F; // '?'

  localparam logic [BYTE_W-1:0] CH_UPPER_LO = 8'h41; // 'A'
  localparam logic [BYTE_W-1:0] CH_UPPER_HI = 8'h5A; // 'Z'

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_ECHO      = 2'd2,
    ST_ECHO_HOLD = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    CMD_NONE       = 4'd0,
    CMD_RUN_STOP   = 4'd1,
    CMD_CLEAR      = 4'd2,
    CMD_MODE       = 4'd3,
    CMD_UP         = 4'd4,
    CMD_DOWN       = 4'd5,
    CMD_TOGGLE_SEL = 4'd6,
    CMD_TOGGLE_SET = 4'd7,
    CMD_DIGIT      = 4'd8,
    CMD_EOL        = 4'd9
  } cmd_t;

  // Upper-case ASCII letters map to lower case; everything else is untouched.
  function automatic logic [BYTE_W-1:0] fold_case(input logic [BYTE_W-1:0] b);
    if (b >= CH_UPPER_LO && b <= CH_UPPER_HI) return b | 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_if.sv
// UART receiver/transmitter handshake seen by the command decoder.
interface uart_cmd_if;
  import uart_cmd_pkg::*;

  logic [BYTE_W-1:0] i_rx_data;
  logic              i_rx_done;
  logic              i_tx_busy;
  logic [BYTE_W-1:0] o_tx_data;
  logic              o_tx_start;

  modport master (
    output i_rx_data, i_rx_done, i_tx_busy,
    input  o_tx_data, o_tx_start
  );

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_busy,
    output o_tx_data, o_tx_start
  );
endinterface

// File: rtl/cmd_lookup.sv
// Combinational map from a case-folded byte to a command code.
module cmd_lookup
  import uart_cmd_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_in,
  output cmd_t              cmd,
  output logic [1:0]        digit,
  output logic              valid
);

  // Decode one folded byte; unknown bytes drop valid.
  always_comb begin
    cmd   = CMD_NONE;
    digit = 2'd0;
    valid = 1'b1;
    case (byte_in)
      CH_RUN_STOP: cmd = CMD_RUN_STOP;
      CH_CLEAR:    cmd = CMD_CLEAR;
      CH_MODE:     cmd = CMD_MODE;
      CH_UP:       cmd = CMD_UP;
      CH_DOWN:     cmd = CMD_DOWN;
      CH_WATCH:    cmd = CMD_TOGGLE_SEL;
      CH_SETTING:  cmd = CMD_TOGGLE_SET;
      CH_DIGIT0, CH_DIGIT1, CH_DIGIT2, CH_DIGIT3: begin
        cmd   = CMD_DIGIT;
        digit = byte_in[1:0];
      end
      CH_CR, CH_LF: cmd = CMD_EOL;
      default:      valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns received bytes into stopwatch/watch control
// pulses and levels, optionally echoing each byte back.
// Build option: define UART_CMD_ECHO_EN to include the echo path.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  uart_cmd_if.slave          bus,
  output logic               o_btn_run_stop,
  output logic               o_btn_clear,
  output logic               o_btn_mode,
  output logic               o_btn_up,
  output logic               o_btn_down,
  output logic               o_mode_sel,
  output logic               o_setting,
  output logic [DIGIT_W-1:0] o_digit_sel,
  output logic               o_err,
  output logic               o_overrun
);

  logic [BYTE_W-1:0] folded;
  cmd_t              cmd;
  logic [1:0]        digit;
  logic              valid;
  state_t            state;

  assign folded = fold_case(bus.i_rx_data);

  cmd_lookup u_lookup (
    .byte_in (folded),
    .cmd     (cmd),
    .digit   (digit),
    .valid   (valid)
  );

  // A strobe outside IDLE is dropped and flagged in the same cycle.
  assign o_overrun = bus.i_rx_done && (state != ST_IDLE);

`ifdef UART_CMD_ECHO_EN
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_unknown;
  logic              rx_eol;
  logic              tx_start;
  logic [BYTE_W-1:0] tx_data;
  logic [BYTE_W-1:0] echo_byte;

  assign echo_byte      = rx_unknown ? CH_QMARK : rx_byte;
  assign bus.o_tx_start = tx_start;
  assign bus.o_tx_data  = tx_data;
`else
  assign bus.o_tx_start = 1'b0;
  assign bus.o_tx_data  = '0;
`endif

  // Control FSM; command pulses are registered so they appear during DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      o_btn_run_stop <= 1'b0;
      o_btn_clear    <= 1'b0;
      o_btn_mode     <= 1'b0;
      o_btn_up       <= 1'b0;
      o_btn_down     <= 1'b0;
      o_err          <= 1'b0;
      o_mode_sel     <= 1'b0;
      o_setting      <= 1'b0;
      o_digit_sel    <= 4'b0001;
`ifdef UART_CMD_ECHO_EN
      rx_byte        <= '0;
      rx_unknown     <= 1'b0;
      rx_eol         <= 1'b0;
      tx_start       <= 1'b0;
      tx_data        <= '0;
`endif
    end else begin
      o_btn_run_stop <= 1'b0;
      o_btn_clear    <= 1'b0;
      o_btn_mode     <= 1'b0;
      o_btn_up       <= 1'b0;
      o_btn_down     <= 1'b0;
      o_err          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_rx_done) begin
            state <= ST_DECODE;
`ifdef UART_CMD_ECHO_EN
            rx_byte    <= bus.i_rx_data;
            rx_unknown <= !valid;
            rx_eol     <= (cmd == CMD_EOL);
`endif
            if (!valid) o_err <= 1'b1;
            case (cmd)
              CMD_RUN_STOP:   o_btn_run_stop <= 1'b1;
              CMD_CLEAR:      o_btn_clear    <= 1'b1;
              CMD_MODE:       o_btn_mode     <= 1'b1;
              CMD_UP:         o_btn_up       <= 1'b1;
              CMD_DOWN:       o_btn_down     <= 1'b1;
              CMD_TOGGLE_SEL: o_mode_sel     <= !o_mode_sel;
              CMD_TOGGLE_SET: o_setting      <= !o_setting;
              CMD_DIGIT:      o_digit_sel    <= 4'b0001 << digit;
              default: ;
            endcase
          end
        end
        ST_DECODE: begin
`ifdef UART_CMD_ECHO_EN
          if (rx_eol) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_ECHO;
            if (!bus.i_tx_busy) begin
              tx_start <= 1'b1;
              tx_data  <= echo_byte;
            end
          end
`else
          state <= ST_IDLE;
`endif
        end
`ifdef UART_CMD_ECHO_EN
        ST_ECHO: begin
          if (tx_start) begin
            tx_start <= 1'b0;
            state    <= ST_ECHO_HOLD;
          end else if (!bus.i_tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= echo_byte;
          end
        end
        ST_ECHO_HOLD: state <= ST_IDLE;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized self-checking bench for uart_cmd_decoder with a transaction-level model.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_stop, clear, mode, up, down, mode_sel, setting, err, overrun;
  logic [3:0] digit_sel;

  uart_cmd_if bus();

  uart_cmd_decoder dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .o_btn_run_stop (run_stop),
    .o_btn_clear    (clear),
    .o_btn_mode     (mode),
    .o_btn_up       (up),
    .o_btn_down     (down),
    .o_mode_sel     (mode_sel),
    .o_setting      (setting),
    .o_digit_sel    (digit_sel),
    .o_err          (err),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

`ifdef UART_CMD_ECHO_EN
  localparam bit ECHO_EN = 1'b1;
`else
  localparam bit ECHO_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state, one transaction at a time.
  int         cyc;
  bit         txn;
  int         acc_cyc;
  int         idle_from;
  int         e_cyc;
  bit         echo_pend;
  logic [7:0] acc_raw;
  bit         m_mode;
  bit         m_set;
  logic [3:0] m_digit;
  logic [7:0] m_txd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cycle=%0d t=%0t", tag, got, exp, cyc, $time);
    end
  endtask

  function automatic logic [7:0] lower(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) return b + 8'd32;
    return b;
  endfunction

  function automatic bit known(input logic [7:0] f);
    return f inside {"r", "c", "m", "u", "d", "w", "s", "0", "1", "2", "3", 8'h0D, 8'h0A};
  endfunction

  task automatic model_reset();
    txn = 0; e_cyc = -1; echo_pend = 0; idle_from = 0; acc_cyc = -10;
    m_mode = 0; m_set = 0; m_digit = 4'b0001; m_txd = 8'h00;
  endtask

  // One clock cycle: drive inputs, compare outputs at negedge, advance model.
  task automatic step(input bit rxd, input logic [7:0] data, input bit busy);
    bit         idle;
    bit         es;
    logic [5:0] ep;
    logic [7:0] f;
    bus.i_rx_done = rxd;
    bus.i_rx_data = rxd ? data : 8'($urandom);
    bus.i_tx_busy = busy;
    @(negedge clk);
    if (txn && cyc >= idle_from) txn = 0;
    idle = !txn;
    ep = '0;
    es = 0;
    if (txn && cyc == acc_cyc + 1) begin
      f = lower(acc_raw);
      case (f)
        "r": ep[5] = 1;
        "c": ep[4] = 1;
        "m": ep[3] = 1;
        "u": ep[2] = 1;
        "d": ep[1] = 1;
        "w": m_mode = !m_mode;
        "s": m_set = !m_set;
        "0", "1", "2", "3": m_digit = 4'b0001 << (f - 8'h30);
        8'h0D, 8'h0A: ;
        default: ep[0] = 1;
      endcase
    end
    if (txn && cyc == e_cyc) begin
      es = 1;
      m_txd = known(lower(acc_raw)) ? acc_raw : 8'h3F;
    end
    check("pulses", 32'({run_stop, clear, mode, up, down, err}), 32'(ep));
    check("overrun", 32'(overrun), 32'(rxd && !idle));
    check("tx", 32'({bus.o_tx_start, bus.o_tx_data}), 32'({es, m_txd}));
    check("levels", 32'({mode_sel, setting, digit_sel}), 32'({m_mode, m_set, m_digit}));
    if (idle && rxd) begin
      txn       = 1;
      acc_cyc   = cyc;
      acc_raw   = data;
      e_cyc     = -1;
      echo_pend = ECHO_EN && !(lower(data) inside {8'h0D, 8'h0A});
      idle_from = echo_pend ? 32'h7fff_ffff : cyc + 2;
    end else if (txn && echo_pend && e_cyc < 0 && cyc >= acc_cyc + 1 && !busy) begin
      e_cyc     = cyc + 1;
      idle_from = cyc + 3;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check(tag, 32'({run_stop, clear, mode, up, down, err, overrun, bus.o_tx_start, bus.o_tx_data,
                    mode_sel, setting, digit_sel}),
          32'({7'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0001}));
  endtask

  logic [7:0] picks [20] = '{"r", "c", "m", "u", "d", "w", "s", "0", "1", "2", "3",
                             "R", "W", "S", "D", 8'h0D, 8'h0A, "x", "?", 8'hC1};

  initial begin
    bit         busy_lvl;
    logic [7:0] b;
    cyc = 0;
    model_reset();
    bus.i_rx_done = 0;
    bus.i_rx_data = 0;
    bus.i_tx_busy = 0;
    reset = 1;
    #12;
    check_reset_values("reset_state");
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;

    // 'r' run/stop with free transmitter
    step(1, 8'h72, 0);
    repeat (5) step(0, 0, 0);
    // 'W' then 'w' toggle watch mode, echoes raw bytes
    step(1, 8'h57, 0);
    repeat (5) step(0, 0, 0);
    step(1, 8'h77, 0);
    repeat (5) step(0, 0, 0);
    // digit select then unknown byte
    step(1, 8'h32, 0);
    repeat (5) step(0, 0, 0);
    step(1, 8'h78, 0);
    repeat (5) step(0, 0, 0);
    // CR / LF: no action
    step(1, 8'h0D, 0);
    step(0, 0, 0);
    step(1, 8'h0A, 0);
    repeat (3) step(0, 0, 0);
    // busy transmitter for 50 cycles with an overrun in the middle
    step(1, 8'h63, 1);
    for (int i = 0; i < 49; i++) step(i == 10, 8'h72, 1);
    repeat (8) step(0, 0, 0);
    // back-to-back strobes: second one lands in DECODE
    step(1, 8'h75, 0);
    step(1, 8'h64, 0);
    repeat (6) step(0, 0, 0);

    // randomized traffic with bursty transmitter busy
    busy_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) busy_lvl = !busy_lvl;
      b = ($urandom_range(4) == 0) ? 8'($urandom) : picks[$urandom_range(19)];
      step($urandom_range(3) == 0, b, busy_lvl);
    end
    repeat (4) step(0, 0, 0);

    // reset during echo wait aborts the echo
    step(1, 8'h6D, 1);
    repeat (4) step(0, 0, 1);
    #2;
    reset = 1;
    #1;
    check_reset_values("reset_mid_echo");
    model_reset();
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    repeat (12) step(0, 0, 0);
    // 'u' after reset still produces the up pulse
    step(1, 8'h75, 0);
    repeat (6) step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
